mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_responder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder.
// master drives the request side; slave returns readdata/response.
interface mem_responder_if #(
   parameter int WIDTH = 32
);
   logic             request;
   logic             wren;
   logic [WIDTH-1:0] address;
   logic [WIDTH-1:0] writedata;
   logic [WIDTH-1:0] readdata;
   logic             response;

   modport master (
      output request,
      output wren,
      output address,
      output writedata,
      input  readdata,
      input  response
   );

   modport slave (
      input  request,
      input  wren,
      input  address,
      input  writedata,
      output readdata,
      output response
   );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding RAM responder with fixed LATENCY (IDLE/BUSY/RESP).
// Define MEM_RESPONDER_BOUNDS_CHECK_EN to reject addresses >= 2**ADDR_BITS.
module mem_responder #(
   parameter int WIDTH     = 32,
   parameter int ADDR_BITS = 10,
   parameter int LATENCY   = 2
) (
   input logic            clk,
   input logic            rst_n,
   mem_responder_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [3:0] CNT_INIT =
      (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             wren_q, wren_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [WIDTH-1:0] mem_q [0:DEPTH-1];

   logic                 enter_resp;
   logic                 oob;
   logic                 mem_we;
   logic [ADDR_BITS-1:0] idx;
   logic                 unused_addr;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wren_d     = wren_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      enter_resp = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.request) begin
               wren_d  = bus.wren;
               addr_d  = bus.address;
               wdata_d = bus.writedata;
               if (LATENCY == 1) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // addr_d/wren_d/wdata_d already select live inputs when LATENCY=1
   assign idx = addr_d[ADDR_BITS-1:0];
   assign unused_addr = ^addr_d;

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
   assign oob = (addr_d >> ADDR_BITS) != '0;
`else
   assign oob = 1'b0;
`endif

   assign mem_we = enter_resp && wren_d && !oob;

   always_comb begin
      rdata_d = rdata_q;
      if (enter_resp && !wren_d) begin
         rdata_d = oob ? '0 : mem_q[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         wren_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wren_q  <= wren_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // RAM keeps its contents through reset; reset only blocks the write
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem_q[idx] <= wdata_d;
      end
   end

   assign bus.response = (state_q == RESP);
   assign bus.readdata = rdata_q;

endmodule
